// File: rtl/rng_share_arbiter_if.sv
// rtl/rng_share_arbiter_if.sv - requester/consumer bundle of the shared random-sample arbiter
interface rng_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16
);
    logic [NUM_REQ-1:0] req;
    logic [WIDTH-1:0]   rng_in;
    logic [NUM_REQ-1:0] gnt;
    logic [WIDTH-1:0]   rnd_out;
    logic               rnd_valid;
    logic               rng_stale;
    logic [15:0]        grant_count;

    modport slave (
        input  req,
        input  rng_in,
        output gnt,
        output rnd_out,
        output rnd_valid,
        output rng_stale,
        output grant_count
    );

    modport master (
        output req,
        output rng_in,
        input  gnt,
        input  rnd_out,
        input  rnd_valid,
        input  rng_stale,
        input  grant_count
    );
endinterface

// File: rtl/rng_share_arbiter.sv
// rtl/rng_share_arbiter.sv - round-robin sharing of one pseudo-random source, never repeating a sample back to back
module rng_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int HOLDOFF = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    rng_share_arbiter_if.slave    bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] HOLD_LAST = 4'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

    state_t             state_q;
    logic [PW-1:0]      ptr_q;
    logic [WIDTH-1:0]   last_q;
    logic               deliv_q;
    logic [3:0]         hold_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [WIDTH-1:0]   rnd_out_q;
    logic               rnd_valid_q;
    logic               stale_q;
    logic [15:0]        grant_count_q;

    logic [PW-1:0]      pick_idx;
    logic               pick_found;
    logic               ready;
    logic               grant_ok;
    logic [PW-1:0]      ptr_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic [15:0]        grant_count_d;

    // Scan downward so the candidate closest to the pointer is written last and wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req[(int'(ptr_q) + k) % NUM_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = PW'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    // The last holdoff edge (or the grant edge itself when HOLDOFF=0) already arbitrates.
    always_comb begin
        ready = 1'b0;
        case (state_q)
            IDLE:    ready = 1'b1;
            GRANT:   ready = (HOLDOFF == 0);
            HOLD:    ready = (hold_q == 4'd0);
            default: ready = 1'b0;
        endcase
    end

    assign grant_ok      = pick_found && (!deliv_q || (bus.rng_in != last_q));
    assign ptr_d         = PW'((int'(pick_idx) + 1) % NUM_REQ);
    assign gnt_d         = NUM_REQ'(1) << pick_idx;
    assign grant_count_d = grant_count_q + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            last_q        <= '0;
            deliv_q       <= 1'b0;
            hold_q        <= 4'd0;
            gnt_q         <= '0;
            rnd_out_q     <= '0;
            rnd_valid_q   <= 1'b0;
            stale_q       <= 1'b0;
            grant_count_q <= 16'd0;
        end else begin
            gnt_q       <= '0;
            rnd_valid_q <= 1'b0;
            if (ready) begin
                if (grant_ok) begin
                    gnt_q         <= gnt_d;
                    rnd_out_q     <= bus.rng_in;
                    rnd_valid_q   <= 1'b1;
                    last_q        <= bus.rng_in;
                    deliv_q       <= 1'b1;
                    ptr_q         <= ptr_d;
                    grant_count_q <= grant_count_d;
                    stale_q       <= 1'b0;
                    state_q       <= GRANT;
                end else begin
                    stale_q <= pick_found;
                    state_q <= IDLE;
                end
            end else begin
                stale_q <= 1'b0;
                if (state_q == GRANT) begin
                    state_q <= HOLD;
                    hold_q  <= HOLD_LAST;
                end else begin
                    hold_q <= hold_q - 4'd1;
                end
            end
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.rnd_out     = rnd_out_q;
    assign bus.rnd_valid   = rnd_valid_q;
    assign bus.rng_stale   = stale_q;
    assign bus.grant_count = grant_count_q;
endmodule
